// File: rtl/tile_mem_pkg.sv
// Shared configuration, request/response types and helpers for the banked tile memory.
package tile_mem_pkg;

    localparam int unsigned N_PORTS_DEF       = 4;
    localparam int unsigned N_MEM_BANKS_DEF   = 16;
    localparam int unsigned N_WORDS_BANK_DEF  = 1024;
    localparam int unsigned N_INSTR_WORDS_DEF = 4096;
    localparam int unsigned BYTE_OFF_W        = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] wdata;
    } tile_mem_req_t;

    typedef struct packed {
        logic        rvalid;
        logic        err;
        logic [31:0] rdata;
    } tile_mem_rsp_t;

    function automatic bit is_pow2(input int unsigned n);
        return (n != 32'd0) && ((n & (n - 32'd1)) == 32'd0);
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/tile_mem_if.sv
// Data-port bundle of the banked tile memory: per-port request and response vectors.
interface tile_mem_if #(
    parameter int unsigned N_PORTS = tile_mem_pkg::N_PORTS_DEF
);
    logic [N_PORTS-1:0]       req_i;
    logic [N_PORTS-1:0][31:0] addr_i;
    logic [N_PORTS-1:0]       wen_i;
    logic [N_PORTS-1:0][3:0]  be_i;
    logic [N_PORTS-1:0][31:0] wdata_i;
    logic [N_PORTS-1:0]       gnt_o;
    logic [N_PORTS-1:0]       rvalid_o;
    logic [N_PORTS-1:0][31:0] rdata_o;
    logic [N_PORTS-1:0]       err_o;

    modport master (
        output req_i, addr_i, wen_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, addr_i, wen_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/tile_mem_rr_arb.sv
// Round-robin arbiter for one bank; the priority pointer moves past each winner.
module tile_mem_rr_arb #(
    parameter  int unsigned N_PORTS = tile_mem_pkg::N_PORTS_DEF,
    localparam int unsigned PW      = tile_mem_pkg::idx_w(N_PORTS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_PORTS-1:0] i_req,
    output logic [N_PORTS-1:0] o_gnt,
    output logic [PW-1:0]      o_idx,
    output logic               o_any
);
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_cand;

    // First requester found when scanning upward from the pointer wins.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            w_cand = PW'((int'(r_ptr) + k) % int'(N_PORTS));
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end else begin
                o_any = o_any;
            end
        end
    end

    // Pointer update after each grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= (o_idx == PW'(N_PORTS - 1)) ? '0 : o_idx + PW'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end
endmodule

// File: rtl/tile_banked_mem.sv
// Word-interleaved multi-bank tile memory with per-bank round-robin arbitration.
// Optional separate read-only instruction array: define TILE_MEM_SEP_INSTR_EN.
module tile_banked_mem
    import tile_mem_pkg::*;
#(
    parameter int unsigned N_PORTS       = N_PORTS_DEF,
    parameter int unsigned N_MEM_BANKS   = N_MEM_BANKS_DEF,
    parameter int unsigned N_WORDS_BANK  = N_WORDS_BANK_DEF,
    parameter int unsigned N_INSTR_WORDS = N_INSTR_WORDS_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    tile_mem_if.slave   bus
`ifdef TILE_MEM_SEP_INSTR_EN
    ,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o
`endif
);
    localparam int unsigned BANK_AW = $clog2(N_MEM_BANKS);
    localparam int unsigned ROW_AW  = $clog2(N_WORDS_BANK);
    localparam int unsigned MEM_AW  = BYTE_OFF_W + BANK_AW + ROW_AW;
    localparam int unsigned PW      = idx_w(N_PORTS);

    if (!is_pow2(N_MEM_BANKS) || !is_pow2(N_WORDS_BANK) || !is_pow2(N_INSTR_WORDS)) begin : g_bad_cfg
        $error("tile_banked_mem: bank count, bank depth and instruction depth must be powers of two");
    end

    tile_mem_req_t      w_req      [N_PORTS];
    logic [BANK_AW-1:0] w_bank     [N_PORTS];
    logic [ROW_AW-1:0]  w_row      [N_PORTS];
    logic [N_PORTS-1:0] w_in_range;
    logic [N_PORTS-1:0] w_gnt;
    logic [N_PORTS-1:0] w_bank_req [N_MEM_BANKS];
    logic [N_PORTS-1:0] w_bank_gnt [N_MEM_BANKS];
    logic [PW-1:0]      w_bank_idx [N_MEM_BANKS];
    logic [N_MEM_BANKS-1:0] w_bank_any;

    logic [31:0]        r_mem [N_MEM_BANKS][N_WORDS_BANK];
    tile_mem_rsp_t      r_rsp [N_PORTS];

    // Address decode and per-bank request vectors.
    always_comb begin
        for (int p = 0; p < int'(N_PORTS); p++) begin
            w_req[p].addr  = bus.addr_i[p];
            w_req[p].wen   = bus.wen_i[p];
            w_req[p].be    = bus.be_i[p];
            w_req[p].wdata = bus.wdata_i[p];
            w_bank[p]      = bus.addr_i[p][BYTE_OFF_W +: BANK_AW];
            w_row[p]       = bus.addr_i[p][BYTE_OFF_W + BANK_AW +: ROW_AW];
            w_in_range[p]  = (bus.addr_i[p] >> MEM_AW) == 32'd0;
        end
        for (int b = 0; b < int'(N_MEM_BANKS); b++) begin
            for (int p = 0; p < int'(N_PORTS); p++) begin
                w_bank_req[b][p] = bus.req_i[p] & w_in_range[p] & (w_bank[p] == BANK_AW'(b));
            end
        end
    end

    for (genvar b = 0; b < int'(N_MEM_BANKS); b++) begin : g_bank_arb
        tile_mem_rr_arb #(.N_PORTS(N_PORTS)) u_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_req  (w_bank_req[b]),
            .o_gnt  (w_bank_gnt[b]),
            .o_idx  (w_bank_idx[b]),
            .o_any  (w_bank_any[b])
        );
    end

    // Out-of-range requests bypass arbitration; nothing is granted in reset.
    always_comb begin
        for (int p = 0; p < int'(N_PORTS); p++) begin
            w_gnt[p]        = rst_ni & bus.req_i[p] & (~w_in_range[p] | w_bank_gnt[w_bank[p]][p]);
            bus.gnt_o[p]    = w_gnt[p];
            bus.rvalid_o[p] = r_rsp[p].rvalid;
            bus.err_o[p]    = r_rsp[p].err;
            bus.rdata_o[p]  = r_rsp[p].rdata;
        end
    end

    // Byte-masked bank writes; the array is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < int'(N_MEM_BANKS); b++) begin
            if (rst_ni && w_bank_any[b] && w_req[w_bank_idx[b]].wen) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_req[w_bank_idx[b]].be[i]) begin
                        r_mem[b][w_row[w_bank_idx[b]]][8*i +: 8] <= w_req[w_bank_idx[b]].wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // One-cycle response; at most one granted port touches a bank, so reads never race writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < int'(N_PORTS); p++) begin
                r_rsp[p] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(N_PORTS); p++) begin
                r_rsp[p].rvalid <= w_gnt[p];
                r_rsp[p].err    <= w_gnt[p] & ~w_in_range[p];
                r_rsp[p].rdata  <= (w_gnt[p] && w_in_range[p] && !w_req[p].wen)
                                   ? r_mem[w_bank[p]][w_row[p]] : 32'd0;
            end
        end
    end

`ifdef TILE_MEM_SEP_INSTR_EN
    localparam int unsigned INSTR_AW = $clog2(N_INSTR_WORDS);

    logic [31:0] r_instr_mem [N_INSTR_WORDS];
    logic        r_instr_rvalid;
    logic [31:0] r_instr_rdata;

    assign instr_gnt_o    = instr_req_i & rst_ni;
    assign instr_rvalid_o = r_instr_rvalid;
    assign instr_rdata_o  = r_instr_rdata;

    // Instruction fetch response, independent of the data banks.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_instr_rvalid <= 1'b0;
            r_instr_rdata  <= 32'd0;
        end else begin
            r_instr_rvalid <= instr_gnt_o;
            r_instr_rdata  <= instr_gnt_o ? r_instr_mem[instr_addr_i[BYTE_OFF_W +: INSTR_AW]] : 32'd0;
        end
    end
`endif
endmodule

// File: doc/tile_banked_mem.md
TILE_BANKED_MEM -- requirements
Module: tile_banked_mem

Interface
REQ-001 SHALL have parameter N_PORTS, 4: number of data master ports.
REQ-002 SHALL have parameter N_MEM_BANKS, 16: number of word-interleaved banks; power of two.
REQ-003 SHALL have parameter N_WORDS_BANK, 1024: 32-bit words per bank; power of two.
REQ-004 SHALL have parameter N_INSTR_WORDS, 4096: instruction array depth; used only with TILE_MEM_SEP_INSTR_EN.
REQ-005 SHALL have port clk_i, input, 1: the single clock.
REQ-006 SHALL have port rst_ni, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port req_i, input, N_PORTS: per-port request.
REQ-008 SHALL have port addr_i, input, N_PORTS x 32: per-port byte address.
REQ-009 SHALL have port wen_i, input, N_PORTS: 1 = write, 0 = read.
REQ-010 SHALL have port be_i, input, N_PORTS x 4: byte enables.
REQ-011 SHALL have port wdata_i, input, N_PORTS x 32: write data.
REQ-012 SHALL have port gnt_o, output, N_PORTS: request accepted this cycle.
REQ-013 SHALL have port rvalid_o, output, N_PORTS: response valid.
REQ-014 SHALL have port rdata_o, output, N_PORTS x 32: read data.
REQ-015 SHALL have port err_o, output, N_PORTS: response error, qualified by rvalid_o.
REQ-016 SHALL have ports instr_req_i (in, 1), instr_addr_i (in, 32), instr_gnt_o (out, 1), instr_rvalid_o (out, 1) and instr_rdata_o (out, 32), present only with TILE_MEM_SEP_INSTR_EN.

Function
REQ-017 SHALL map each address as: bank = addr[2 +: log2(N_MEM_BANKS)]; row = next log2(N_WORDS_BANK) bits; addr[1:0] ignored.
REQ-018 SHALL treat an address at or above N_MEM_BANKS*N_WORDS_BANK*4 as out of range.
REQ-019 SHALL arbitrate each bank independently among requesting ports with round-robin; per-bank priority pointer resets to port 0 and moves to (winner+1) mod N_PORTS after each grant.
REQ-020 SHALL assert gnt_o combinationally in the request cycle; a port holds req/addr/wen/be/wdata stable until it is granted.
REQ-021 SHALL grant at most one port per bank per cycle; ports on different banks are granted in the same cycle.
REQ-022 SHALL assert rvalid_o exactly one cycle after gnt_o, for reads and writes; rdata_o = 0 for writes.
REQ-023 SHALL write only bytes whose be_i bit is 1; a read issued the cycle after a write to the same word returns the new data.
REQ-024 SHALL grant out-of-range requests immediately without bank arbitration, never write memory, and respond one cycle later with err_o=1, rdata_o=0.
REQ-025 SHALL hold rdata_o, rvalid_o and err_o at 0 in any cycle with no response.

Reset
REQ-026 SHALL drive gnt_o, rvalid_o, rdata_o, err_o (and instr outputs) to 0 while rst_ni is low, and reset all priority pointers to 0.
REQ-027 SHALL drop an in-flight response when reset asserts mid-operation, and SHALL NOT reset memory contents.

Configuration
REQ-028 With TILE_MEM_SEP_INSTR_EN defined, SHALL add a separate read-only instruction array of N_INSTR_WORDS words at word index addr[2 +: log2(N_INSTR_WORDS)]; instr_gnt_o = instr_req_i; instr_rvalid_o one cycle later; no contention with data ports.
REQ-029 Without TILE_MEM_SEP_INSTR_EN, SHALL omit the instruction ports and array; instruction fetch uses a data port (shared instruction/data memory).

Structure
REQ-030 SHALL take parameter defaults, address-slicing widths and the req/rsp struct typedefs from shared package tile_mem_pkg.
REQ-031 SHALL implement per-bank arbitration in one sub-module tile_mem_rr_arb, instantiated N_MEM_BANKS times.

Verification
REQ-032 Port 0 writes 0xDEADBEEF to 0x40 with be=0xF, then reads 0x40 -> gnt both cycles, rvalid next cycles, rdata=0xDEADBEEF, err=0.
REQ-033 Word 0x0 holds 0x11223344; write be=0x2 data 0xAABBCCDD -> subsequent read returns 0x1122CC44.
REQ-034 Ports 0-3 all read bank 0 (0x0, 0x40, 0x80, 0xC0) continuously -> grants rotate 0,1,2,3,0; each port granted once every 4 cycles.
REQ-035 Ports 0-3 read 0x0, 0x4, 0x8, 0xC in the same cycle -> all granted the same cycle, all rvalid next cycle.
REQ-036 Port 2 writes 0x10000 (default size 64 KiB) -> gnt, next-cycle err=1, rdata=0; memory unchanged.
REQ-037 Reset pulsed the cycle after a grant -> rvalid stays 0; a read of that word after reset returns its pre-reset contents.
